// File: rtl/dpram_pkg.sv
// Shared definitions for the dual-port RAM: read-during-write policy codes,
// clear-sequencer states and the byte-enable merge used on writes.
package dpram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int MERGE_MAX_W = 1024;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Returns old_w with every byte whose enable is set replaced by new_w's byte.
  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0]   old_w,
    input logic [MERGE_MAX_W-1:0]   new_w,
    input logic [MERGE_MAX_W/8-1:0] be
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MERGE_MAX_W/8; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dpram_clear_fsm.sv
// Post-reset clear sequencer: walks every word once, issuing a zero-write
// strobe per cycle, and holds busy until the last word has been written.
//
// state | meaning
// IDLE  | normal operation, no clear writes
// CLEAR | writing zero to word r_clr_ptr this cycle
module dpram_clear_fsm
  import dpram_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DEPTH        = 256,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam state_t            RST_STATE = (CLEAR_ON_RST != 0) ? CLEAR : IDLE;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_ptr;

  // State register; reset restarts the clear from the beginning.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= RST_STATE;
    else       r_state <= w_state_nxt;
  end

  // Clear pointer advances one word per clearing cycle and parks at zero otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state != CLEAR)) r_clr_ptr <= '0;
    else                             r_clr_ptr <= r_clr_ptr + 1'b1;
  end

  // Next state and clear write strobe.
  always_comb begin
    w_state_nxt = r_state;
    o_clr_we    = 1'b0;
    case (r_state)
      CLEAR: begin
        o_clr_we = 1'b1;
        if (r_clr_ptr == LAST_ADDR) w_state_nxt = IDLE;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  assign o_busy     = (r_state == CLEAR);
  assign o_clr_addr = r_clr_ptr;

endmodule

// File: rtl/dual_port_ram_p.sv
// Simple dual-port synchronous RAM (one write port, one read port, one clock)
// with byte enables, selectable read-during-write policy, 1/2-cycle read
// latency, out-of-range detection and an optional zero-fill after reset.
module dual_port_ram_p
  import dpram_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 8,
  parameter int DEPTH        = 256,
  parameter int RD_LAT       = 1,
  parameter int RDW_MODE     = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write_en,
  input  logic [ADDR_W-1:0]   write_addr,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [DATA_W/8-1:0] write_be,
  input  logic                read_en,
  input  logic [ADDR_W-1:0]   read_addr,
  output logic [DATA_W-1:0]   read_out,
  output logic                read_valid,
  output logic                busy,
  output logic                addr_err
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_read_out;
  logic              r_read_valid;
  logic              r_addr_err;

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_in;
  logic              w_rd_in;
  logic              w_wr_ok;
  logic              w_rd_acc;
  logic              w_coll;
  logic [DATA_W-1:0] w_wr_merged;
  logic [DATA_W-1:0] w_rd_data;

  dpram_clear_fsm #(
    .ADDR_W       (ADDR_W),
    .DEPTH        (DEPTH),
    .CLEAR_ON_RST (CLEAR_ON_RST)
  ) u_clear_fsm (
    .i_clk      (clk),
    .i_rst      (rst),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  assign w_wr_in  = ({1'b0, write_addr} < DEPTH_LIM);
  assign w_rd_in  = ({1'b0, read_addr}  < DEPTH_LIM);
  assign w_wr_ok  = write_en && !w_busy && !rst && w_wr_in;
  assign w_rd_acc = read_en  && !w_busy && !rst;
  assign w_coll   = w_wr_ok && w_rd_in && (write_addr == read_addr);

  // Merged write word and the data an accepted read will return.
  always_comb begin
    w_wr_merged = DATA_W'(byte_merge(MERGE_MAX_W'(r_mem[write_addr]),
                                     MERGE_MAX_W'(write_data),
                                     (MERGE_MAX_W/8)'(write_be)));
    w_rd_data   = '0;
    if (w_rd_in) begin
      if (w_coll && (RDW_MODE == RDW_WRITE_FIRST)) w_rd_data = w_wr_merged;
      else                                         w_rd_data = r_mem[read_addr];
    end
  end

  // Storage: clear writes own the port while busy, user writes otherwise.
  always_ff @(posedge clk) begin
    if (w_clr_we)     r_mem[w_clr_addr] <= '0;
    else if (w_wr_ok) r_mem[write_addr] <= w_wr_merged;
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              r_s1_valid;
      logic [DATA_W-1:0] r_s1_data;
      // Two-stage read pipeline: capture at acceptance, present one edge later.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_s1_valid   <= 1'b0;
          r_s1_data    <= '0;
          r_read_valid <= 1'b0;
          r_read_out   <= '0;
        end else begin
          r_s1_valid   <= w_rd_acc;
          r_s1_data    <= w_rd_acc ? w_rd_data : '0;
          r_read_valid <= r_s1_valid;
          if (r_s1_valid) r_read_out <= r_s1_data;
        end
      end
    end else begin : g_lat1
      // Single-stage read: data presented at the accepting edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_read_valid <= 1'b0;
          r_read_out   <= '0;
        end else begin
          r_read_valid <= w_rd_acc;
          if (w_rd_acc) r_read_out <= w_rd_data;
        end
      end
    end
  endgenerate

  // Out-of-range pulse for either port's request.
  always_ff @(posedge clk) begin
    if (rst) r_addr_err <= 1'b0;
    else     r_addr_err <= !w_busy && ((write_en && !w_wr_in) || (read_en && !w_rd_in));
  end

  assign read_out   = r_read_out;
  assign read_valid = r_read_valid;
  assign busy       = w_busy;
  assign addr_err   = r_addr_err;

endmodule

// File: tb/tb_dual_port_ram_p.sv
// Bench for dual_port_ram_p: two instances with different configurations
// share one stimulus stream; a word-level model predicts every output.
module tb_dual_port_ram_p;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic        re  = 1'b0;
  logic [7:0]  wa  = '0;
  logic [7:0]  ra  = '0;
  logic [31:0] wd  = '0;
  logic [3:0]  be  = '0;

  logic [31:0] out_a, out_b;
  logic        val_a, val_b, busy_a, busy_b, err_a, err_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dual_port_ram_p #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .RD_LAT(1),
                    .RDW_MODE(0), .CLEAR_ON_RST(1)) u_a (
    .clk(clk), .rst(rst), .write_en(we), .write_addr(wa), .write_data(wd),
    .write_be(be), .read_en(re), .read_addr(ra), .read_out(out_a),
    .read_valid(val_a), .busy(busy_a), .addr_err(err_a));

  dual_port_ram_p #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .RD_LAT(2),
                    .RDW_MODE(1), .CLEAR_ON_RST(1)) u_b (
    .clk(clk), .rst(rst), .write_en(we), .write_addr(wa), .write_data(wd),
    .write_be(be), .read_en(re), .read_addr(ra), .read_out(out_b),
    .read_valid(val_b), .busy(busy_b), .addr_err(err_b));

  function automatic int dep_of(input int k);
    return (k == 0) ? 256 : 200;
  endfunction
  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction
  function automatic bit wfirst_of(input int k);
    return (k == 0) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  bit          model_ok = 1'b0;
  int          since   [2];
  logic [31:0] mm      [2][256];
  bit          hv      [2][4];
  logic [31:0] hd      [2][4];
  bit          e_valid [2];
  bit          e_err   [2];
  bit          e_busy  [2];
  logic [31:0] e_out   [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      since[k] = 0; e_valid[k] = 0; e_err[k] = 0; e_busy[k] = 1; e_out[k] = '0;
      for (int j = 0; j < 4; j++) begin hv[k][j] = 0; hd[k][j] = '0; end
      for (int j = 0; j < 256; j++) mm[k][j] = '0;
    end
  end

  always @(posedge clk) begin
    bit          bz, wr_ok, rd_acc;
    int          dep, slot;
    logic [31:0] rdat;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      dep = dep_of(k);
      if (rst) begin
        since[k] = 0;
        for (int j = 0; j < 4; j++) hv[k][j] = 0;
        e_valid[k] = 0; e_out[k] = '0; e_err[k] = 0; e_busy[k] = 1;
      end else begin
        bz = (since[k] < dep);
        if (bz) begin
          since[k]++;
          if (since[k] == dep) for (int j = 0; j < 256; j++) mm[k][j] = '0;
        end
        rd_acc = re && !bz;
        wr_ok  = we && !bz && (int'(wa) < dep);
        rdat   = '0;
        if (rd_acc && (int'(ra) < dep)) begin
          rdat = mm[k][ra];
          if (wfirst_of(k) && wr_ok && (wa == ra)) rdat = bmerge(rdat, wd, be);
        end
        if (wr_ok) mm[k][wa] = bmerge(mm[k][wa], wd, be);
        e_err[k] = !bz && ((we && int'(wa) >= dep) || (re && int'(ra) >= dep));
        hv[k][cyc % 4] = rd_acc;
        hd[k][cyc % 4] = rdat;
        slot = (cyc + 4 - (lat_of(k) - 1)) % 4;
        e_valid[k] = hv[k][slot];
        if (e_valid[k]) e_out[k] = hd[k][slot];
        e_busy[k] = (since[k] < dep);
      end
    end
    if (rst) model_ok = 1'b1;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("a_valid", {31'b0, val_a},  {31'b0, e_valid[0]});
      chk("a_out",   out_a,           e_out[0]);
      chk("a_busy",  {31'b0, busy_a}, {31'b0, e_busy[0]});
      chk("a_err",   {31'b0, err_a},  {31'b0, e_err[0]});
      chk("b_valid", {31'b0, val_b},  {31'b0, e_valid[1]});
      chk("b_out",   out_b,           e_out[1]);
      chk("b_busy",  {31'b0, busy_b}, {31'b0, e_busy[1]});
      chk("b_err",   {31'b0, err_b},  {31'b0, e_err[1]});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1; wa = a; wd = d; be = b;
    step();
    we = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] exp_a,
                         input logic [31:0] exp_b);
    re = 1'b1; ra = a;
    step();
    re = 1'b0;
    chk("lit_rd_a_valid", {31'b0, val_a}, 32'd1);
    chk("lit_rd_a_data",  out_a,          exp_a);
    chk("lit_rd_b_early", {31'b0, val_b}, 32'd0);
    step();
    chk("lit_rd_b_valid", {31'b0, val_b}, 32'd1);
    chk("lit_rd_b_data",  out_b,          exp_b);
    chk("lit_rd_a_once",  {31'b0, val_a}, 32'd0);
  endtask

  task automatic count_busy(output int ca, output int cb);
    ca = 0; cb = 0;
    for (int i = 0; i < 600; i++) begin
      if (!busy_a && !busy_b) break;
      if (busy_a) ca++;
      if (busy_b) cb++;
      step();
    end
  endtask

  initial begin
    int ca, cb;
    #1;
    step(); step();
    // Clear after reset, with a read request that must be ignored.
    rst = 1'b0;
    re = 1'b1; ra = 8'd12;
    step();
    re = 1'b0;
    count_busy(ca, cb);
    chk("lit_busy_len_a", ca, 32'd255);
    chk("lit_busy_len_b", cb, 32'd199);
    do_read(8'd12, 32'd0, 32'd0);

    // Plain write then read.
    wr(8'd12, 32'd244, 4'hF);
    do_read(8'd12, 32'd244, 32'd244);

    // Byte enables.
    wr(8'd20, 32'hAABBCCDD, 4'hF);
    wr(8'd20, 32'h11223344, 4'b0010);
    do_read(8'd20, 32'hAABB33DD, 32'hAABB33DD);

    // Same-address collision: read-first on a, write-first on b.
    we = 1'b1; wa = 8'd12; wd = 32'h55; be = 4'hF; re = 1'b1; ra = 8'd12;
    step();
    we = 1'b0; re = 1'b0;
    chk("lit_coll_a", out_a, 32'd244);
    step();
    chk("lit_coll_b", out_b, 32'h55);
    do_read(8'd12, 32'h55, 32'h55);

    // Out of range for b only (DEPTH=200).
    wr(8'd210, 32'd7, 4'hF);
    chk("lit_oor_wr_err_b", {31'b0, err_b}, 32'd1);
    chk("lit_oor_wr_err_a", {31'b0, err_a}, 32'd0);
    step();
    chk("lit_oor_err_pulse", {31'b0, err_b}, 32'd0);
    re = 1'b1; ra = 8'd210;
    step();
    re = 1'b0;
    chk("lit_oor_rd_err_b", {31'b0, err_b}, 32'd1);
    chk("lit_oor_rd_a",     out_a,          32'd7);
    step();
    chk("lit_oor_rd_valid_b", {31'b0, val_b}, 32'd1);
    chk("lit_oor_rd_data_b",  out_b,          32'd0);

    // Reset in the middle of a clear restarts it from word 0.
    wr(8'd30, 32'hDEADBEEF, 4'hF);
    rst = 1'b1; step(); rst = 1'b0;
    repeat (100) step();
    chk("lit_midclear_busy", {31'b0, busy_a}, 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    count_busy(ca, cb);
    chk("lit_restart_len_a", ca, 32'd256);
    chk("lit_restart_len_b", cb, 32'd200);
    do_read(8'd30, 32'd0, 32'd0);
    do_read(8'd20, 32'd0, 32'd0);

    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/dual_port_ram_p.md
Name: dual_port_ram_p

Overview:
Parametrised simple dual-port synchronous RAM: one write port and one read port, both on a single clock. It adds byte-enable writes, a selectable read-during-write policy, 1- or 2-cycle read latency with a read_valid strobe, out-of-range address detection, and an optional hardware clear sequence after reset. It is the general storage primitive used by buffers and register files in the design.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8.
ADDR_W, 8, address width in bits.
DEPTH, 256, number of words; 1 <= DEPTH <= 2^ADDR_W.
RD_LAT, 1, read latency in cycles; legal values are 1 or 2.
RDW_MODE, 0, same-address read/write policy: 0 = read-first (old data), 1 = write-first (new data).
CLEAR_ON_RST, 1, 1 = zero all words after reset; 0 = contents untouched by reset.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
write_en  in  1  write request.
write_addr  in  ADDR_W  write word address.
write_data  in  DATA_W  write data.
write_be  in  DATA_W/8  byte enables; bit i covers data bits [8i+7:8i].
read_en  in  1  read request.
read_addr  in  ADDR_W  read word address.
read_out  out  DATA_W  read data.
read_valid  out  1  one-cycle strobe; read_out is valid while it is high.
busy  out  1  clear sequence in progress; requests are ignored.
addr_err  out  1  one-cycle pulse: a request used an address >= DEPTH.

Behaviour:
- Reset values: read_out=0, read_valid=0, addr_err=0, all read pipeline stages=0.
- Reset with CLEAR_ON_RST=1: busy=1 and FSM state=CLEAR. With CLEAR_ON_RST=0: busy=0 and state=IDLE.
- FSM state IDLE: normal operation.
- FSM state CLEAR:
  - Each cycle, writes 0 to mem[clr_ptr] and increments clr_ptr, which starts at 0.
  - After the cycle that writes clr_ptr==DEPTH-1, moves to IDLE.
  - busy is high for exactly DEPTH cycles after rst deasserts.
- rst asserted mid-clear: clr_ptr returns to 0 and the full clear restarts. rst asserted mid-read: pipeline flushes and read_valid=0.
- While busy: write_en and read_en are ignored. No memory change, no read_valid, no addr_err.
- Write, when write_en && !busy && write_addr<DEPTH: at the clock edge, mem[write_addr] byte i takes write_data byte i for each write_be[i]=1. Other bytes keep their value.
- Read acceptance: read_en && !busy. The address is sampled at that edge.
  - RD_LAT=1: read_out and read_valid update at the next edge.
  - RD_LAT=2: they update one edge later.
  - One accepted read gives one read_valid cycle. Back-to-back reads give back-to-back valids, fully pipelined.
- read_out holds its last value when no read completes. read_valid=0 in that case.
- Collision (accepted read and write to the same in-range address in the same cycle):
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merged word (new bytes where be=1, old bytes where be=0).
- Out of range (address >= DEPTH; only possible when DEPTH < 2^ADDR_W):
  - Write is dropped.
  - Read is still accepted: read_valid asserts at normal latency with read_out=0.
  - addr_err pulses at the edge after the offending request (either or both ports).
- Address comparisons are unsigned. The memory array is not reset except by the CLEAR sequence.

Decomposition:
- Shared package dpram_pkg holds:
  - constants RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1;
  - enum state_t {IDLE, CLEAR};
  - a byte-merge function (old, new, be) -> word.
- One sub-module, dpram_clear_fsm: owns state, clr_ptr and busy. It outputs the clear write strobe and address, which the top muxes onto the write port.

Test Plan:
1. CLEAR_ON_RST=1, DEPTH=256: pulse rst, then read addr 12 immediately -> busy high for exactly 256 cycles and the read is ignored (no read_valid). After busy falls, read 12 -> read_out=0, read_valid one cycle later.
2. RD_LAT=1: write 12 = 244 with be=4'hF, next cycle read 12 -> read_out=244, read_valid=1 exactly one cycle after the read. With RD_LAT=2, the same result two cycles after.
3. Byte enables: write 20 = 32'hAABBCCDD (be=F), then write 20 = 32'h11223344 with be=4'b0010, read 20 -> 32'hAABB33DD.
4. Collision: mem[12]=244; same cycle write 12 = 32'h55 (be=F) and read 12 -> RDW_MODE=0 returns 244, RDW_MODE=1 returns 32'h55. A following read of 12 returns 32'h55 in both modes.
5. DEPTH=200: write 210 = 7 -> addr_err pulses once and no word changes. Read 210 -> read_valid=1, read_out=0, addr_err pulse.
6. Reset mid-clear: assert rst for one cycle at clear cycle 100 -> busy stays high and deasserts 256 cycles after the second rst release. Any words written before that reset read back as 0.
